dot_product: RTL and testbench

Weighted-sum stage sitting directly upstream of the sigmoid activation unit in each neuron. It accepts a vector of N unsigned 8-bit activations and computes their dot product with N locally held signed Q8.8 weights using one serial multiplier. It presents the saturated 16-bit sum on the sigmoid's argument handshake. When training is enabled, it consumes the sigmoid's 16-bit feedback delta and applies a per-weight gradient update before accepting the next vector.

---
 rtl/machina_pkg.sv | 24 ++
 rtl/dot_product_weight_bank.sv | 31 +++
 rtl/dot_product.sv | 124 ++++++++++++
 tb/tb_dot_product.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/machina_pkg.sv
// Shared fixed-point constants, FSM encoding and saturation helper for the neuron datapath.
package machina_pkg;

    localparam int Q_W   = 16;
    localparam int ACT_W = 8;

    typedef logic [2:0] state_t;
    localparam state_t ST_INP = 3'd0;
    localparam state_t ST_MAC = 3'd1;
    localparam state_t ST_ARG = 3'd2;
    localparam state_t ST_DEL = 3'd3;
    localparam state_t ST_UPD = 3'd4;

    // Clamp a wide signed value into the Q8.8 range.
    function automatic logic signed [Q_W-1:0] sat16(input logic signed [31:0] v);
        if (v > 32'sd32767)
            return 16'sh7fff;
        else if (v < -32'sd32768)
            return 16'sh8000;
        else
            return v[Q_W-1:0];
    endfunction

endpackage

// File: rtl/dot_product_weight_bank.sv
// N Q8.8 weight registers, one read port and one write port, async reset to WINIT.
module weight_bank
    import machina_pkg::*;
#(
    parameter int                     N     = 4,
    parameter logic signed [Q_W-1:0]  WINIT = 16'sh0100,
    localparam int                    IW    = $clog2(N)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [IW-1:0]         rd_idx,
    output logic signed [Q_W-1:0] rd_dat,
    input  logic                  wr_en,
    input  logic [IW-1:0]         wr_idx,
    input  logic signed [Q_W-1:0] wr_dat
);

    logic [N-1:0][Q_W-1:0] w_q;

    for (genvar g = 0; g < N; g++) begin : g_w
        always_ff @(posedge clk or negedge rst) begin
            if (!rst)
                w_q[g] <= WINIT;
            else if (wr_en && wr_idx == IW'(g))
                w_q[g] <= wr_dat;
        end
    end

    assign rd_dat = w_q[rd_idx];

endmodule

// File: rtl/dot_product.sv
// Serial-MAC weighted sum feeding the sigmoid, with optional per-weight gradient update.
module dot_product
    import machina_pkg::*;
#(
    parameter int                     N     = 4,
    parameter logic signed [Q_W-1:0]  WINIT = 16'sh0100,
    parameter int                     RATE  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   inp_stb,
    input  logic [ACT_W*N-1:0]     inp_dat,
    output logic                   inp_rdy,
    output logic                   arg_stb,
    output logic [Q_W-1:0]         arg_dat,
    input  logic                   arg_rdy,
    input  logic                   del_stb,
    input  logic [Q_W-1:0]         del_dat,
    output logic                   del_rdy
);

    localparam int IW     = $clog2(N);
    localparam int PROD_W = Q_W + ACT_W + 1;
    localparam int ACC_W  = PROD_W + $clog2(N);

    state_t                    state_q, state_d;
    logic [IW-1:0]             idx_q;
    logic [N-1:0][ACT_W-1:0]   x_q;
    logic signed [ACC_W-1:0]   acc_q;
    logic signed [Q_W-1:0]     delta_q;
    logic signed [Q_W-1:0]     arg_dat_q;

    logic signed [Q_W-1:0]     w_rd;
    logic signed [ACT_W:0]     x_s;
    logic signed [PROD_W-1:0]  prod, dprod, dstep;
    logic signed [ACC_W-1:0]   acc_sum, acc_shr;
    logic signed [Q_W-1:0]     sum_sat, upd_val;
    logic                      last, inp_ack, arg_ack, del_ack;

    weight_bank #(.N(N), .WINIT(WINIT)) u_bank (
        .clk    (clk),
        .rst    (rst),
        .rd_idx (idx_q),
        .rd_dat (w_rd),
        .wr_en  (state_q == ST_UPD),
        .wr_idx (idx_q),
        .wr_dat (upd_val)
    );

    // Activations are unsigned; a zero sign bit keeps the signed multiply exact.
    assign x_s     = $signed({1'b0, x_q[idx_q]});
    assign prod    = PROD_W'(w_rd) * PROD_W'(x_s);
    assign acc_sum = acc_q + ACC_W'(prod);
    assign acc_shr = acc_sum >>> 8;
    assign sum_sat = sat16(32'(acc_shr));

    assign dprod   = PROD_W'(delta_q) * PROD_W'(x_s);
    assign dstep   = dprod >>> (8 + RATE);
    assign upd_val = sat16(32'(w_rd) + 32'(dstep));

    assign last    = (idx_q == IW'(N - 1));
    assign inp_ack = inp_stb & inp_rdy;
    assign arg_ack = arg_stb & arg_rdy;
    assign del_ack = del_stb & del_rdy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_q <= ST_INP;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INP: if (inp_ack) state_d = ST_MAC;
            ST_MAC: if (last)    state_d = ST_ARG;
            ST_ARG: if (arg_ack) state_d = en ? ST_DEL : ST_INP;
            ST_DEL: if (del_ack) state_d = ST_UPD;
            ST_UPD: if (last)    state_d = ST_INP;
            default:             state_d = ST_INP;
        endcase
    end

    always_comb begin
        inp_rdy = (state_q == ST_INP);
        arg_stb = (state_q == ST_ARG);
        del_rdy = (state_q == ST_DEL);
    end

    assign arg_dat = arg_dat_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q     <= '0;
            x_q       <= '0;
            acc_q     <= '0;
            delta_q   <= '0;
            arg_dat_q <= '0;
        end else begin
            case (state_q)
                ST_INP: if (inp_ack) begin
                    x_q   <= inp_dat;
                    acc_q <= '0;
                    idx_q <= '0;
                end
                ST_MAC: begin
                    acc_q <= acc_sum;
                    idx_q <= last ? '0 : idx_q + IW'(1);
                    if (last)
                        arg_dat_q <= sum_sat;
                end
                ST_DEL: if (del_ack) begin
                    delta_q <= del_dat;
                    idx_q   <= '0;
                end
                ST_UPD: idx_q <= last ? '0 : idx_q + IW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dot_product.sv
// Directed bench for dot_product: forward pass, saturation, training, backpressure, reset abort.
module tb_dot_product;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        inp_stb = 1'b0;
    logic [31:0] inp_dat = '0;
    logic        arg_rdy = 1'b0;
    logic        del_stb = 1'b0;
    logic [15:0] del_dat = '0;

    logic        inp_rdy, arg_stb, del_rdy;
    logic [15:0] arg_dat;
    logic        inp_rdy_hi, arg_stb_hi, del_rdy_hi;
    logic [15:0] arg_dat_hi;
    logic        inp_rdy_lo, arg_stb_lo, del_rdy_lo;
    logic [15:0] arg_dat_lo;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dot_product #(.N(N)) dut (
        .clk(clk), .rst(rst), .en(en), .inp_stb(inp_stb), .inp_dat(inp_dat),
        .inp_rdy(inp_rdy), .arg_stb(arg_stb), .arg_dat(arg_dat), .arg_rdy(arg_rdy),
        .del_stb(del_stb), .del_dat(del_dat), .del_rdy(del_rdy)
    );

    dot_product #(.N(N), .WINIT(16'sh7fff)) dut_hi (
        .clk(clk), .rst(rst), .en(en), .inp_stb(inp_stb), .inp_dat(inp_dat),
        .inp_rdy(inp_rdy_hi), .arg_stb(arg_stb_hi), .arg_dat(arg_dat_hi), .arg_rdy(arg_rdy),
        .del_stb(del_stb), .del_dat(del_dat), .del_rdy(del_rdy_hi)
    );

    dot_product #(.N(N), .WINIT(16'sh8000)) dut_lo (
        .clk(clk), .rst(rst), .en(en), .inp_stb(inp_stb), .inp_dat(inp_dat),
        .inp_rdy(inp_rdy_lo), .arg_stb(arg_stb_lo), .arg_dat(arg_dat_lo), .arg_rdy(arg_rdy),
        .del_stb(del_stb), .del_dat(del_dat), .del_rdy(del_rdy_lo)
    );

    // Offer one vector from a negedge in INP; return latency (negedges after ack) and arg_dat.
    task automatic run_pass(input logic [7:0] x, input logic en_v,
                            output int lat, output logic [15:0] dat);
        inp_stb = 1'b1;
        inp_dat = {N{x}};
        en      = en_v;
        @(negedge clk);
        inp_stb = 1'b0;
        inp_dat = '0;
        lat = 1;
        while (!arg_stb && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!arg_stb) lat = -1;
        dat = arg_dat;
    endtask

    task automatic accept_arg();
        arg_rdy = 1'b1;
        @(negedge clk);
        arg_rdy = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (inp_rdy !== 1'b1 || arg_stb !== 1'b0 || del_rdy !== 1'b0 || arg_dat !== 16'h0000) begin
            errors++;
            $display("FAIL reset_outputs: inp_rdy=%b arg_stb=%b del_rdy=%b arg_dat=%h, want 1 0 0 0000",
                     inp_rdy, arg_stb, del_rdy, arg_dat);
        end
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            checks++;
            if (dut.u_bank.w_q[i] !== 16'h0100) begin
                errors++;
                $display("FAIL reset_weight[%0d]: got %h want 0100", i, dut.u_bank.w_q[i]);
            end
        end
        checks++;
        if (inp_rdy !== 1'b1 || arg_stb !== 1'b0 || del_rdy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: inp_rdy=%b arg_stb=%b del_rdy=%b, want 1 0 0",
                     inp_rdy, arg_stb, del_rdy);
        end
    endtask

    task automatic test_forward();
        int lat;
        logic [15:0] dat;
        run_pass(8'h80, 1'b0, lat, dat);
        checks++;
        if (lat != 5) begin
            errors++;
            $display("FAIL fwd_latency: got %0d want 5", lat);
        end
        checks++;
        if (dat !== 16'h0200) begin
            errors++;
            $display("FAIL fwd_data: got %h want 0200", dat);
        end
        checks++;
        if (inp_rdy !== 1'b0 || del_rdy !== 1'b0) begin
            errors++;
            $display("FAIL fwd_excl: inp_rdy=%b del_rdy=%b want 0 0", inp_rdy, del_rdy);
        end
        accept_arg();
        checks++;
        if (inp_rdy !== 1'b1 || arg_stb !== 1'b0 || del_rdy !== 1'b0) begin
            errors++;
            $display("FAIL fwd_return: inp_rdy=%b arg_stb=%b del_rdy=%b want 1 0 0",
                     inp_rdy, arg_stb, del_rdy);
        end
    endtask

    task automatic test_saturation();
        int lat;
        logic [15:0] dat;
        run_pass(8'hff, 1'b0, lat, dat);
        checks++;
        if (dat !== 16'h03fc) begin
            errors++;
            $display("FAIL sat_nominal: got %h want 03fc", dat);
        end
        checks++;
        if (arg_dat_hi !== 16'h7fff) begin
            errors++;
            $display("FAIL sat_high: got %h want 7fff", arg_dat_hi);
        end
        checks++;
        if (arg_dat_lo !== 16'h8000) begin
            errors++;
            $display("FAIL sat_low: got %h want 8000", arg_dat_lo);
        end
        accept_arg();
    endtask

    task automatic test_training();
        int lat;
        logic [15:0] dat;
        run_pass(8'h80, 1'b1, lat, dat);
        checks++;
        if (dat !== 16'h0200) begin
            errors++;
            $display("FAIL train_fwd: got %h want 0200", dat);
        end
        en = 1'b1;
        accept_arg();
        en = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (del_rdy !== 1'b1 || inp_rdy !== 1'b0 || arg_stb !== 1'b0) begin
            errors++;
            $display("FAIL train_del_wait: del_rdy=%b inp_rdy=%b arg_stb=%b want 1 0 0",
                     del_rdy, inp_rdy, arg_stb);
        end
        del_stb = 1'b1;
        del_dat = 16'h1000;
        @(negedge clk);
        del_stb = 1'b0;
        del_dat = 16'h7777;
        for (int k = 1; k <= N; k++) begin
            @(negedge clk);
            checks++;
            if (inp_rdy !== (k == N)) begin
                errors++;
                $display("FAIL train_upd_cycle%0d: inp_rdy=%b want %b", k, inp_rdy, k == N);
            end
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (dut.u_bank.w_q[i] !== 16'h0180) begin
                errors++;
                $display("FAIL train_weight[%0d]: got %h want 0180", i, dut.u_bank.w_q[i]);
            end
        end
        run_pass(8'h80, 1'b0, lat, dat);
        checks++;
        if (dat !== 16'h0300) begin
            errors++;
            $display("FAIL train_next: got %h want 0300", dat);
        end
        accept_arg();
        checks++;
        if (dut.u_bank.w_q[0] !== 16'h0180 || inp_rdy !== 1'b1) begin
            errors++;
            $display("FAIL train_noen: w0=%h inp_rdy=%b want 0180 1", dut.u_bank.w_q[0], inp_rdy);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        int bad;
        logic [15:0] dat;
        run_pass(8'h80, 1'b0, lat, dat);
        bad = 0;
        // Stray strobes and an en change while stalled must not disturb anything.
        inp_stb = 1'b1;
        inp_dat = 32'h0;
        del_stb = 1'b1;
        en      = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (arg_stb !== 1'b1 || arg_dat !== 16'h0300 || inp_rdy !== 1'b0 || del_rdy !== 1'b0)
                bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bp_hold: %0d unstable cycles, last arg_stb=%b arg_dat=%h inp_rdy=%b del_rdy=%b",
                     bad, arg_stb, arg_dat, inp_rdy, del_rdy);
        end
        inp_stb = 1'b0;
        del_stb = 1'b0;
        en      = 1'b0;
        accept_arg();
        checks++;
        if (inp_rdy !== 1'b1 || del_rdy !== 1'b0 || arg_stb !== 1'b0) begin
            errors++;
            $display("FAIL bp_accept: inp_rdy=%b del_rdy=%b arg_stb=%b want 1 0 0",
                     inp_rdy, del_rdy, arg_stb);
        end
    endtask

    task automatic test_reset_abort();
        int lat;
        logic [15:0] dat;
        inp_stb = 1'b1;
        inp_dat = {N{8'h80}};
        en      = 1'b1;
        @(negedge clk);
        inp_stb = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (inp_rdy !== 1'b1 || arg_stb !== 1'b0 || del_rdy !== 1'b0 || arg_dat !== 16'h0000) begin
            errors++;
            $display("FAIL abort_outputs: inp_rdy=%b arg_stb=%b del_rdy=%b arg_dat=%h want 1 0 0 0000",
                     inp_rdy, arg_stb, del_rdy, arg_dat);
        end
        checks++;
        if (dut.u_bank.w_q[3] !== 16'h0100) begin
            errors++;
            $display("FAIL abort_weight: got %h want 0100", dut.u_bank.w_q[3]);
        end
        en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run_pass(8'h80, 1'b0, lat, dat);
        checks++;
        if (lat != 5 || dat !== 16'h0200) begin
            errors++;
            $display("FAIL abort_rerun: lat=%0d data=%h want 5 0200", lat, dat);
        end
        accept_arg();
    endtask

    initial begin
        test_reset();
        test_forward();
        test_saturation();
        test_training();
        test_backpressure();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule
